pc_branch_sequencer: RTL

PC_BRANCH_SEQUENCER -- requirements
Module: pc_branch_sequencer

---
 rtl/pc_seq_pkg.sv | 12 +
 rtl/pc_target_adder.sv | 22 ++
 rtl/pc_branch_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the PC / branch sequencer.
//   PC_ADDR_BITS  default program-address width
//   seq_state_e   sequencer FSM states
package pc_seq_pkg;
  localparam int unsigned PC_ADDR_BITS = 16;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    INT_ENTRY = 2'd2
  } seq_state_e;
endpackage

// File: rtl/pc_target_adder.sv
// pc_target_adder: combinational branch-target select.
//   i_pc        current PC
//   i_offset    signed two's-complement displacement
//   i_absolute  absolute target
//   i_relative  1 = PC+offset, 0 = absolute
//   o_target    selected target
module pc_target_adder #(
  parameter int unsigned AddrBits = 16
) (
  input  logic [AddrBits-1:0] i_pc,
  input  logic [AddrBits-1:0] i_offset,
  input  logic [AddrBits-1:0] i_absolute,
  input  logic                i_relative,
  output logic [AddrBits-1:0] o_target
);
  logic [AddrBits-1:0] w_rel_target;

  // Offset is already AddrBits wide, so sign extension is implicit and the
  // truncated sum is exactly (PC + offset) mod 2^AddrBits.
  assign w_rel_target = i_pc + i_offset;
  assign o_target     = i_relative ? w_rel_target : i_absolute;
endmodule

// File: rtl/pc_branch_sequencer.sv
// pc_branch_sequencer: program counter with branch, single-level interrupt
// and return-from-interrupt sequencing.
//   Clock, Reset (async, active high), Tick (advance qualifier)
//   Stall, BranchValid/BranchCond/BranchRelative/BranchOffset/BranchAbsolute
//   IntReq/IntVector, ReturnFromInt
//   PC, FetchValid, Flush, InIsr, BranchAddrD/BranchAddrEn (downstream
//   branch-instruction-address register D / clock enable)
module pc_branch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned          AddrBits    = PC_ADDR_BITS,
  parameter logic [AddrBits-1:0]  ResetVector = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                Stall,
  input  logic                BranchValid,
  input  logic                BranchCond,
  input  logic                BranchRelative,
  input  logic [AddrBits-1:0] BranchOffset,
  input  logic [AddrBits-1:0] BranchAbsolute,
  input  logic                IntReq,
  input  logic [AddrBits-1:0] IntVector,
  input  logic                ReturnFromInt,
  output logic [AddrBits-1:0] PC,
  output logic                FetchValid,
  output logic                Flush,
  output logic                InIsr,
  output logic [AddrBits-1:0] BranchAddrD,
  output logic                BranchAddrEn
);
  seq_state_e          r_state;
  logic [AddrBits-1:0] r_pc;
  logic [AddrBits-1:0] r_epc;
  logic                r_in_isr;

  logic [AddrBits-1:0] w_target;
  logic                w_run_adv;
  logic                w_int;
  logic                w_ret;
  logic                w_br_taken;

  pc_target_adder #(.AddrBits(AddrBits)) u_target (
    .i_pc      (r_pc),
    .i_offset  (BranchOffset),
    .i_absolute(BranchAbsolute),
    .i_relative(BranchRelative),
    .o_target  (w_target)
  );

  // Decision chain in RUN: stall > interrupt > return > branch > increment.
  assign w_run_adv  = Tick && !Reset && (r_state == RUN) && !Stall;
  assign w_int      = w_run_adv && IntReq && !r_in_isr;
  assign w_ret      = w_run_adv && !w_int && ReturnFromInt && r_in_isr;
  assign w_br_taken = w_run_adv && !w_int && !w_ret && BranchValid && BranchCond;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= FLUSH;
      r_pc     <= ResetVector;
      r_epc    <= '0;
      r_in_isr <= 1'b0;
    end else if (Tick) begin
      case (r_state)
        RUN: begin
          if (!Stall) begin
            if (w_int) begin
              r_epc    <= r_pc;
              r_pc     <= IntVector;
              r_in_isr <= 1'b1;
              r_state  <= INT_ENTRY;
            end else if (w_ret) begin
              r_pc     <= r_epc;
              r_in_isr <= 1'b0;
              r_state  <= FLUSH;
            end else if (w_br_taken) begin
              r_pc     <= w_target;
              r_state  <= FLUSH;
            end else begin
              r_pc     <= r_pc + 1'b1;
            end
          end
        end
        // One-tick bubble: PC held, all requests ignored.
        FLUSH, INT_ENTRY: r_state <= RUN;
        default:          r_state <= FLUSH;
      endcase
    end
  end

  assign PC           = r_pc;
  assign InIsr        = r_in_isr;
  assign FetchValid   = (r_state == RUN) && !Stall && !Reset;
  assign Flush        = (r_state != RUN) || Reset;
  assign BranchAddrD  = r_pc;
  assign BranchAddrEn = w_br_taken;
endmodule
